// File: rtl/dual_port_sram_arbiter_if.sv
// Client-side bundle for dual_port_sram_arbiter: read/write handshakes of clients A and B.
// master = datapath client side, slave = arbiter side.
interface dual_port_sram_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  a_wr_req;
    logic [ADDR_WIDTH-1:0] a_wr_addr;
    logic [WIDTH-1:0]      a_wr_data;
    logic                  a_wr_gnt;
    logic                  a_rd_req;
    logic [ADDR_WIDTH-1:0] a_rd_addr;
    logic                  a_rd_gnt;
    logic                  a_rd_valid;
    logic [WIDTH-1:0]      a_rd_data;

    logic                  b_wr_req;
    logic [ADDR_WIDTH-1:0] b_wr_addr;
    logic [WIDTH-1:0]      b_wr_data;
    logic                  b_wr_gnt;
    logic                  b_rd_req;
    logic [ADDR_WIDTH-1:0] b_rd_addr;
    logic                  b_rd_gnt;
    logic                  b_rd_valid;
    logic [WIDTH-1:0]      b_rd_data;

    modport master (
        output a_wr_req, a_wr_addr, a_wr_data, a_rd_req, a_rd_addr,
        output b_wr_req, b_wr_addr, b_wr_data, b_rd_req, b_rd_addr,
        input  a_wr_gnt, a_rd_gnt, a_rd_valid, a_rd_data,
        input  b_wr_gnt, b_rd_gnt, b_rd_valid, b_rd_data
    );

    modport slave (
        input  a_wr_req, a_wr_addr, a_wr_data, a_rd_req, a_rd_addr,
        input  b_wr_req, b_wr_addr, b_wr_data, b_rd_req, b_rd_addr,
        output a_wr_gnt, a_rd_gnt, a_rd_valid, a_rd_data,
        output b_wr_gnt, b_rd_gnt, b_rd_valid, b_rd_data
    );
endinterface

// File: rtl/dual_port_sram_arbiter.sv
// Two-client round-robin arbiter for a dual-port SRAM: independent write and read arbitration,
// registered SRAM control pins, and a tag pipeline that routes read data back to its requester.
module dual_port_sram_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dual_port_sram_arbiter_if.slave bus,
    output logic [ADDR_WIDTH-1:0] sram_read_address,
    output logic [ADDR_WIDTH-1:0] sram_write_address,
    output logic [WIDTH-1:0]      sram_write_data,
    output logic                  sram_chip_select,
    output logic                  sram_write_enable,
    output logic                  sram_output_enable,
    input  logic [WIDTH-1:0]      sram_read_data
);

    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } client_t;

    client_t               wr_prio;
    client_t               rd_prio;
    client_t               wr_winner;
    client_t               rd_winner;
    logic                  wr_any;
    logic                  rd_any;
    logic                  hazard;
    logic                  wr_go;
    logic                  rd_go;
    logic [ADDR_WIDTH-1:0] wr_addr_win;
    logic [ADDR_WIDTH-1:0] rd_addr_win;
    logic [WIDTH-1:0]      wr_data_win;

    logic [READ_LATENCY-1:0] tag_valid;
    client_t                 tag_id [READ_LATENCY];
    logic                    in_flight;
    logic                    a_valid_q;
    logic                    b_valid_q;

    // Winner selection; prio only matters when both clients request at once.
    always_comb begin
        wr_any    = bus.a_wr_req | bus.b_wr_req;
        rd_any    = bus.a_rd_req | bus.b_rd_req;
        wr_winner = CLIENT_A;
        rd_winner = CLIENT_A;
        if (bus.a_wr_req && bus.b_wr_req) begin
            wr_winner = wr_prio;
        end else if (bus.b_wr_req) begin
            wr_winner = CLIENT_B;
        end
        if (bus.a_rd_req && bus.b_rd_req) begin
            rd_winner = rd_prio;
        end else if (bus.b_rd_req) begin
            rd_winner = CLIENT_B;
        end
        wr_addr_win = (wr_winner == CLIENT_B) ? bus.b_wr_addr : bus.a_wr_addr;
        wr_data_win = (wr_winner == CLIENT_B) ? bus.b_wr_data : bus.a_wr_data;
        rd_addr_win = (rd_winner == CLIENT_B) ? bus.b_rd_addr : bus.a_rd_addr;
        // A read colliding with this cycle's write waits one cycle so it sees the new data.
        hazard = wr_any && rd_any && (rd_addr_win == wr_addr_win);
        wr_go  = wr_any;
        rd_go  = rd_any && !hazard;
    end

    assign bus.a_wr_gnt = wr_go && (wr_winner == CLIENT_A);
    assign bus.b_wr_gnt = wr_go && (wr_winner == CLIENT_B);
    assign bus.a_rd_gnt = rd_go && (rd_winner == CLIENT_A);
    assign bus.b_rd_gnt = rd_go && (rd_winner == CLIENT_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prio <= CLIENT_A;
            rd_prio <= CLIENT_A;
        end else begin
            if (wr_go) begin
                wr_prio <= (wr_winner == CLIENT_A) ? CLIENT_B : CLIENT_A;
            end
            if (rd_go) begin
                rd_prio <= (rd_winner == CLIENT_A) ? CLIENT_B : CLIENT_A;
            end
        end
    end

    assign in_flight = |tag_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_read_address  <= '0;
            sram_write_address <= '0;
            sram_write_data    <= '0;
            sram_chip_select   <= 1'b0;
            sram_write_enable  <= 1'b0;
            sram_output_enable <= 1'b0;
        end else begin
            sram_write_enable  <= wr_go;
            sram_chip_select   <= wr_go | rd_go | in_flight;
            sram_output_enable <= rd_go | in_flight;
            if (wr_go) begin
                sram_write_address <= wr_addr_win;
                sram_write_data    <= wr_data_win;
            end
            if (rd_go) begin
                sram_read_address <= rd_addr_win;
            end
        end
    end

    // READ_LATENCY tag stages plus the registered valid outputs give the full return delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_id[i] <= CLIENT_A;
            end
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            tag_valid[0] <= rd_go;
            tag_id[0]    <= rd_winner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
            a_valid_q <= tag_valid[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == CLIENT_A);
            b_valid_q <= tag_valid[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == CLIENT_B);
        end
    end

    assign bus.a_rd_valid = a_valid_q;
    assign bus.b_rd_valid = b_valid_q;
    assign bus.a_rd_data  = sram_read_data;
    assign bus.b_rd_data  = sram_read_data;

endmodule

// File: doc/dual_port_sram_arbiter.md
# dual_port_sram_arbiter

Two-client arbiter and sequencer for `dual_port_sram`. Clients A and B each issue independent read and write requests. Writes and reads are arbitrated separately and round-robin onto the SRAM's write and read ports, which can both be used in the same cycle. The block drives the SRAM control pins as registers and returns read data to the client that issued the read. It sits between the SRAM instance and two datapath masters, for example a producer/consumer pair or a DMA and a CPU.

## Interface
- `WIDTH`, 32, data word width
- `DEPTH`, 16, SRAM words
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width
- `READ_LATENCY`, 1, SRAM cycles from control pins to valid `sram_read_data`; legal range 1..4

Ports (all client ports exist once for `a_` and once for `b_`):
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `x_wr_req`  in  1  write request, level
- `x_wr_addr`  in  ADDR_WIDTH  write address
- `x_wr_data`  in  WIDTH  write data
- `x_wr_gnt`  out  1  combinational; write accepted this cycle
- `x_rd_req`  in  1  read request, level
- `x_rd_addr`  in  ADDR_WIDTH  read address
- `x_rd_gnt`  out  1  combinational; read accepted this cycle
- `x_rd_valid`  out  1  registered; read data valid this cycle
- `x_rd_data`  out  WIDTH  equals `sram_read_data`; meaningful only while `x_rd_valid`=1
- `sram_read_address`, `sram_write_address`  out  ADDR_WIDTH  registered
- `sram_write_data`  out  WIDTH  registered
- `sram_chip_select`, `sram_write_enable`, `sram_output_enable`  out  1  registered
- `sram_read_data`  in  WIDTH  from SRAM

## Operation
- **Handshake.** A request is accepted on a rising edge where `req`=1 and `gnt`=1.
  - Clients hold `req`, `addr` and `data` stable until granted.
  - `gnt` depends only on the current `req`/`addr` inputs and on internal state.
- **Write arbitration.** Requests are granted round-robin by a 1-bit `wr_prio` register.
  - One requester only: it is granted.
  - Both requesting: the client selected by `wr_prio` is granted.
  - After any write grant, `wr_prio` points to the non-granted client.
- **Read arbitration.** Identical scheme using an independent `rd_prio` register.
- **Same-cycle hazard.** If the winning read address equals the winning write address in the same cycle, the read grant is suppressed for that cycle.
  - The write proceeds.
  - `rd_prio` does not change.
  - The read is granted the next cycle, so it returns the newly written data.
- **SRAM pins, cycle after a grant.**
  - Write granted: `sram_write_enable`=1, with the winner's address and data registered.
  - Read granted: `sram_read_address` takes the winner's address.
  - `sram_chip_select` = 1 if any grant occurred in the previous cycle, or any read is in flight.
  - `sram_output_enable` = 1 if a read was granted in the previous cycle, or any read is in flight.
  - With no grant, address and data registers hold their values and `sram_write_enable`=0.
- **Read return.** A tag pipeline of depth `READ_LATENCY`+1 carries (valid, client id).
  - `x_rd_valid` is asserted for exactly one cycle per accepted read.
  - Responses return in grant order. With one read per cycle, back-to-back responses are fully pipelined.

## Timing
- **Reset** (asynchronous assert, synchronous release):
  - All `sram_*` outputs are 0.
  - `x_rd_valid` is 0.
  - The tag pipeline is cleared.
  - `wr_prio` and `rd_prio` both select A.
- **Grant.** Read granted in cycle T → SRAM pins driven in T+1 → `x_rd_valid`=1 in T+1+`READ_LATENCY` (T+2 at default).
- **Write.** Write granted in T → `sram_write_enable`=1 in T+1. A read of the same address granted in T+1 or later returns the new data.
- **Simultaneous events.**
  - Read and write from different clients to different addresses in the same cycle are both granted.
  - The same client reading and writing in the same cycle is legal, subject to the hazard rule.
- **Reset mid-operation.** In-flight reads are dropped and no `x_rd_valid` is produced for them. After release, the next request is granted in the first cycle that `req`=1.
- **Addresses.** No range check and no wrap logic. Addresses ≥ `DEPTH` are passed through unchanged.

## Test plan
1. **Single-client sequence.** After reset, A writes addresses 0..15 with `$random` values, then reads 0..15 back to back.
   - `a_wr_gnt` and `a_rd_gnt` are 1 on every cycle.
   - Data matches, with `a_rd_valid` in T+2.
   - `b_*_valid` is never 1.
2. **Write contention.** A and B request writes every cycle, A to address 3 and B to address 4.
   - Grants alternate A, B, A, ..., starting with A after reset.
   - Final readback: addr3 = last A data, addr4 = last B data.
3. **Read contention.** After preloading, A reads 5 and B reads 6 continuously.
   - `x_rd_valid` alternates A/B every cycle.
   - Data always equals the preloaded word for the requesting client's address.
4. **Hazard.** Addr 7 = 0x11111111. In one cycle, A writes 0xDEADBEEF to 7 while B reads 7.
   - `b_rd_gnt`=0 that cycle and 1 the next.
   - B receives 0xDEADBEEF.
5. **Reset mid-read.** B's read is granted; `rst_n` is pulsed low in T+1.
   - No `b_rd_valid` at T+2.
   - All `sram_*` outputs are 0 during reset.
   - The first request after reset is granted immediately.
6. **`READ_LATENCY`=3 rerun of scenario 1.** `a_rd_valid` arrives in T+4 with correct data and no drops at full rate.
